// File: rtl/fpu_pkg.sv
// fpu_pkg: shared single-precision widths, rounding-mode codes and operand unpacking
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MW = FRAC_W + 1;
  localparam int FW = FRAC_W + 4;
  localparam int EXP_BIAS = 127;
  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0] mant;
    logic is_nan;
    logic is_inf;
  } unpacked_t;
  function automatic unpacked_t unpack(input logic [EXP_W+FRAC_W:0] op);
    unpacked_t u;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    e = op[FRAC_W +: EXP_W];
    f = op[FRAC_W-1:0];
    u.sign = op[EXP_W+FRAC_W];
    u.exp = (e == '0) ? EXP_W'(1) : e;
    u.mant = {e != '0, f};
    u.is_nan = (&e) && (|f);
    u.is_inf = (&e) && !(|f);
    return u;
  endfunction
endpackage

// File: rtl/align_shift27.sv
// align_shift27: right shift of an aligned fraction, OR-ing every shifted-out bit into bit 0
module align_shift27 #(
  parameter int FW = 27,
  parameter int SW = 8
) (
  input  logic [FW-1:0] din,
  input  logic [SW-1:0] sh,
  output logic [FW-1:0] dout
);
  logic [FW-1:0] shifted;
  logic [FW-1:0] lost_mask;
  logic sticky;
  assign shifted = din >> sh;
  assign lost_mask = ~({FW{1'b1}} << sh);
  assign sticky = |(din & lost_mask);
  assign dout = {shifted[FW-1:1], shifted[0] | sticky};
endmodule

// File: rtl/pre_norm_addsub_pipe.sv
// pre_norm_addsub_pipe: two-stage unpack/order then align pre-normaliser feeding add_sub27
module pre_norm_addsub_pipe
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              add,
  input  logic [31:0]       opa,
  input  logic [31:0]       opb,
  input  logic [1:0]        rmode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FW-1:0]     fracta,
  output logic [FW-1:0]     fractb,
  output logic              add_eff,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign,
  output logic [1:0]        rmode_out,
  output logic              nan,
  output logic              inf
);
  unpacked_t ua, ub;
  logic swap, eq_mag, add_e, sb_eff, sign_c, nan_c, inf_c;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [MW-1:0] s1_ml, s1_ms;
  logic [EXP_W-1:0] s1_diff, s1_exp;
  logic s1_sign, s1_add, s1_nan, s1_inf;
  logic [1:0] s1_rm;
  logic [FW-1:0] fb_al;
  assign s2_adv = ~s2_valid | out_ready;
  assign s1_adv = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;
  assign ua = unpack(opa);
  assign ub = unpack(opb);
  assign swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};
  assign eq_mag = {ub.exp, ub.mant} == {ua.exp, ua.mant};
  assign add_e = add ^ ua.sign ^ ub.sign;
  assign sb_eff = ub.sign ^ ~add;
  assign sign_c = (eq_mag && !add_e) ? (rmode == RM_RDN) : (swap ? sb_eff : ua.sign);
  assign nan_c = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & ~add_e);
  assign inf_c = (ua.is_inf | ub.is_inf) & ~nan_c;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ml <= '0;
      s1_ms <= '0;
      s1_diff <= '0;
      s1_exp <= '0;
      s1_sign <= 1'b0;
      s1_add <= 1'b0;
      s1_nan <= 1'b0;
      s1_inf <= 1'b0;
      s1_rm <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ml <= swap ? ub.mant : ua.mant;
        s1_ms <= swap ? ua.mant : ub.mant;
        s1_exp <= swap ? ub.exp : ua.exp;
        s1_diff <= swap ? ub.exp - ua.exp : ua.exp - ub.exp;
        s1_sign <= sign_c;
        s1_add <= add_e;
        s1_nan <= nan_c;
        s1_inf <= inf_c;
        s1_rm <= rmode;
      end
    end
  end
  align_shift27 #(.FW(FW), .SW(EXP_W)) u_align (
    .din ({s1_ms, 3'b000}),
    .sh  (s1_diff),
    .dout(fb_al)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      fracta <= '0;
      fractb <= '0;
      add_eff <= 1'b0;
      exp_out <= '0;
      sign <= 1'b0;
      rmode_out <= '0;
      nan <= 1'b0;
      inf <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        fracta <= {s1_ml, 3'b000};
        fractb <= fb_al;
        add_eff <= s1_add;
        exp_out <= s1_exp;
        sign <= s1_sign;
        rmode_out <= s1_rm;
        nan <= s1_nan;
        inf <= s1_inf;
      end
    end
  end
endmodule

// File: tb/tb_pre_norm_addsub_pipe.sv
// tb_pre_norm_addsub_pipe: directed-vector self-checking bench for the pre-normaliser pipeline
module tb_pre_norm_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic add = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [1:0] rmode = '0;
  logic in_ready, out_valid, add_eff, sign, nan, inf;
  logic [26:0] fracta, fractb;
  logic [7:0] exp_out;
  logic [1:0] rmode_out;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pre_norm_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .add(add), .opa(opa), .opb(opb), .rmode(rmode),
    .out_valid(out_valid), .out_ready(out_ready),
    .fracta(fracta), .fractb(fractb), .add_eff(add_eff), .exp_out(exp_out),
    .sign(sign), .rmode_out(rmode_out), .nan(nan), .inf(inf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic ad,
                         input logic [1:0] rm, output int lat);
    opa = a; opb = b; add = ad; rmode = rm;
    in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      step;
      lat++;
    end
    if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
  endtask
  task automatic drain;
    in_valid = 1'b0; out_ready = 1'b1;
    step;
    step;
  endtask
  initial begin
    int lat;
    int got;
    logic [7:0] res [3];
    logic acc;
    step;
    step;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fracta", 32'(fracta), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    rst_n = 1'b1;
    step;
    run_one(32'h3F800000, 32'h3F800000, 1'b1, 2'd0, lat);
    check("t1_lat", 32'(lat), 32'd2);
    check("t1_fracta", 32'(fracta), 32'h4000000);
    check("t1_fractb", 32'(fractb), 32'h4000000);
    check("t1_exp", 32'(exp_out), 32'h7F);
    check("t1_add_eff", 32'(add_eff), 32'd1);
    check("t1_sign", 32'(sign), 32'd0);
    run_one(32'h3F800000, 32'h40000000, 1'b0, 2'd0, lat);
    check("t2_fracta", 32'(fracta), 32'h4000000);
    check("t2_fractb", 32'(fractb), 32'h2000000);
    check("t2_exp", 32'(exp_out), 32'h80);
    check("t2_add_eff", 32'(add_eff), 32'd0);
    check("t2_sign", 32'(sign), 32'd1);
    run_one(32'h4B800000, 32'h3F800001, 1'b1, 2'd0, lat);
    check("t3_fractb", 32'(fractb), 32'h0000005);
    check("t3_exp", 32'(exp_out), 32'h97);
    run_one(32'h4D800000, 32'h3F800000, 1'b1, 2'd0, lat);
    check("t3b_fractb", 32'(fractb), 32'h0000001);
    run_one(32'h7F800000, 32'h7F800000, 1'b0, 2'd0, lat);
    check("t6_nan", 32'(nan), 32'd1);
    check("t6_inf", 32'(inf), 32'd0);
    run_one(32'h7FC00000, 32'h3F800000, 1'b1, 2'd0, lat);
    check("t6b_nan", 32'(nan), 32'd1);
    run_one(32'h3F800000, 32'h3F800000, 1'b0, 2'd3, lat);
    check("t6c_sign", 32'(sign), 32'd1);
    check("t6c_add_eff", 32'(add_eff), 32'd0);
    check("t6c_rmode", 32'(rmode_out), 32'd3);
    run_one(32'h3F800000, 32'h3F800000, 1'b0, 2'd0, lat);
    check("cancel_rne_sign", 32'(sign), 32'd0);
    run_one(32'h7F800000, 32'h3F800000, 1'b1, 2'd0, lat);
    check("inf_inf", 32'(inf), 32'd1);
    check("inf_nan", 32'(nan), 32'd0);
    check("inf_exp", 32'(exp_out), 32'hFF);
    run_one(32'h00000000, 32'h3F800000, 1'b1, 2'd0, lat);
    check("zero_fracta", 32'(fracta), 32'h4000000);
    check("zero_fractb", 32'(fractb), 32'h0);
    check("zero_exp", 32'(exp_out), 32'h7F);
    drain;
    out_ready = 1'b0;
    opa = 32'h3F800000; opb = 32'h3F800000; add = 1'b1; rmode = 2'd0; in_valid = 1'b1;
    check("t4_rdy_a", 32'(in_ready), 32'd1);
    step;
    opa = 32'h40000000;
    check("t4_rdy_b", 32'(in_ready), 32'd1);
    step;
    opa = 32'h40800000;
    for (int i = 0; i < 4; i++) begin
      check("t4_stall_rdy", 32'(in_ready), 32'd0);
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      check("t4_stall_exp", 32'(exp_out), 32'h7F);
      step;
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      acc = in_valid & in_ready;
      if (out_valid) begin
        res[got] = exp_out;
        got++;
      end
      step;
      if (acc) in_valid = 1'b0;
    end
    check("t4_count", 32'(got), 32'd3);
    check("t4_res0", 32'(res[0]), 32'h7F);
    check("t4_res1", 32'(res[1]), 32'h80);
    check("t4_res2", 32'(res[2]), 32'h81);
    step;
    check("t4_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    opa = 32'h40000000; opb = 32'h3F800000; in_valid = 1'b1;
    step;
    step;
    in_valid = 1'b0;
    check("t5_full_valid", 32'(out_valid), 32'd1);
    check("t5_full_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_rdy", 32'(in_ready), 32'd1);
    check("t5_fracta", 32'(fracta), 32'd0);
    check("t5_fractb", 32'(fractb), 32'd0);
    check("t5_exp", 32'(exp_out), 32'd0);
    step;
    step;
    check("t5_no_partial", 32'(out_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
